weight_loader: RTL and testbench
================================

# weight_loader

Write-side initiator for the per-neuron weight memories. Accepts a 16-bit word stream (header word followed by weight words), decodes the target neuron, and drives that memory's one-hot write enable, incrementing write address and write data, one weight per cycle. Sits between the host/DMA configuration path and the array of weight memories in a layer. Also keeps a sticky per-neuron "loaded" map and an error flag for malformed headers.

## Interface
- numNeuron, 30, number of weight memories driven (1..64)
- numWeight, 784, depth of each weight memory (1..1024)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- load_en  in  1  permits stream acceptance; s_ready = load_en when not in reset
- s_valid  in  1  stream word valid
- s_data  in  16  stream word (header or weight)
- s_ready  out  1  stream word accepted on s_valid && s_ready
- clr  in  1  synchronous clear of nrn_loaded and err
- wen  out  numNeuron  one-hot write enable, bit n to memory n
- wadd  out  10  write address, shared by all memories
- win  out  16  write data, shared by all memories
- busy  out  1  high while in LOAD state
- done  out  1  one-cycle pulse with the last write of a block
- nrn_loaded  out  numNeuron  sticky: bit n set when a full valid block for neuron n completed
- err  out  1  sticky: a bad header was received

## Operation
- States: HDR (reset state), LOAD.
- HDR: on accepted word, decode header: idx = s_data[15:10], cnt = s_data[9:0] + 1 (1..1024). Latch idx, cnt; clear word counter; go LOAD.
- Header checks: idx >= numNeuron → bad_idx; cnt > numWeight → over. Either sets err (sticky).
- LOAD: each accepted word w at position k (0-based): if !bad_idx and k < numWeight then wen[idx] pulses, wadd = k, win = w; otherwise word is consumed with wen = 0.
- On acceptance of word k = cnt-1: return to HDR; done pulses (even for bad blocks); nrn_loaded[idx] set only if !bad_idx and !over.
- Words are never dropped while s_ready is low; s_valid without s_ready holds state.
- clr: clears nrn_loaded and err next edge; does not affect state machine. If clr and a set event coincide, the set wins.
- A header for an already-loaded neuron is legal; it overwrites from address 0.
- Counter width 11 bits so cnt = 1024 does not wrap.

## Timing
- All outputs registered. Reset values: wen = 0, wadd = 0, win = 0, busy = 0, done = 0, nrn_loaded = 0, err = 0; s_ready = 0 while rst_n low, else load_en (combinational).
- Write latency: word accepted at edge t → wen/wadd/win valid in cycle after t, for exactly one cycle; back-to-back words give back-to-back writes, throughput 1 word/cycle.
- Header costs one cycle of acceptance, no write; first weight may follow the header in the very next cycle.
- done, nrn_loaded bit, and err update on the same edge the last write is presented (err on the header's following edge).
- busy high from the edge after header acceptance through the edge after the last weight acceptance.
- wadd/win hold last value when wen = 0.
- Reset asserted mid-block: immediate return to HDR, all outputs to reset values; partial block does not set nrn_loaded.

## Test plan
- Basic load: numNeuron=4, numWeight=8; stream 0x0C07 (idx 3, cnt 8) then 0x1000..0x1007 continuous → wen=4'b1000 for 8 consecutive cycles, wadd 0..7, win 0x1000..0x1007, done with wadd=7, nrn_loaded=4'b1000, err=0.
- Backpressure/gaps: same block with s_valid toggling and load_en low for 3 cycles mid-block → identical write sequence, no writes while stalled, no duplicates.
- Bad index: header 0x1403 (idx 5 ≥ 4) + 4 words → no wen, done after 4th word, err=1, nrn_loaded unchanged; next valid header 0x0001 + 2 words loads neuron 0 normally.
- Overlong count: header 0x0409 (idx 1, cnt 10) → writes at wadd 0..7 only, 2 extra words consumed, err=1, nrn_loaded[1]=0, done after 10th word.
- Back-to-back blocks: 0x0000,0xAAAA,0x0800,0xBBBB with no gaps → wen[0] at wadd 0 = 0xAAAA, then wen[2] at wadd 0 = 0xBBBB, two done pulses, nrn_loaded=4'b0101; then clr → nrn_loaded=0, err=0.
- Reset mid-block: rst_n low after 3 of 8 weights → outputs at reset values immediately, s_ready=0; after release, next word is decoded as a header.

Source files
------------

// File: rtl/weight_loader.sv
// weight_loader: turns a header + weight word stream into one-hot writes into the
// per-neuron weight memories, keeping a sticky loaded map and a bad-header flag.
module weight_loader #(
   parameter int numNeuron = 30,
   parameter int numWeight = 784
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_en,
   input  logic                 s_valid,
   input  logic [15:0]          s_data,
   output logic                 s_ready,
   input  logic                 clr,
   output logic [numNeuron-1:0] wen,
   output logic [9:0]           wadd,
   output logic [15:0]          win,
   output logic                 busy,
   output logic                 done,
   output logic [numNeuron-1:0] nrn_loaded,
   output logic                 err
);
   typedef enum logic [0:0] {HDR = 1'b0, LOAD = 1'b1} state_t;

   localparam logic [6:0]           NUM_NRN_W = 7'(numNeuron);
   localparam logic [10:0]          NUM_WT_W  = 11'(numWeight);
   localparam logic [numNeuron-1:0] WEN_ONE   = numNeuron'(1);

   state_t               state_q, state_d;
   logic [5:0]           idx_q, idx_d;
   logic [10:0]          cnt_q, cnt_d, k_q, k_d;
   logic                 bad_idx_q, bad_idx_d, over_q, over_d;
   logic [numNeuron-1:0] wen_d, loaded_d;
   logic [9:0]           wadd_d;
   logic [15:0]          win_d;
   logic                 busy_d, done_d, err_d;
   logic                 accept_s, last_s, hdr_bad_idx_s, hdr_over_s;
   logic [10:0]          hdr_cnt_s;

   assign s_ready       = rst_n & load_en;
   assign accept_s      = s_valid & s_ready;
   assign last_s        = (k_q == (cnt_q - 11'd1));
   // Count field is stored minus one; 11 bits keep a count of 1024 from wrapping.
   assign hdr_cnt_s     = {1'b0, s_data[9:0]} + 11'd1;
   assign hdr_bad_idx_s = ({1'b0, s_data[15:10]} >= NUM_NRN_W);
   assign hdr_over_s    = (hdr_cnt_s > NUM_WT_W);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HDR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HDR: begin
            if (accept_s) state_d = LOAD;
            else          state_d = HDR;
         end
         LOAD: begin
            if (accept_s && last_s) state_d = HDR;
            else                    state_d = LOAD;
         end
         default: state_d = HDR;
      endcase
   end

   // Output and block-context next values; a set of a loaded bit or err overrides clr.
   always_comb begin
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      bad_idx_d = bad_idx_q;
      over_d    = over_q;
      wen_d     = '0;
      wadd_d    = wadd;
      win_d     = win;
      done_d    = 1'b0;
      busy_d    = (state_d == LOAD);
      loaded_d  = clr ? '0 : nrn_loaded;
      err_d     = clr ? 1'b0 : err;
      case (state_q)
         HDR: begin
            if (accept_s) begin
               idx_d     = s_data[15:10];
               cnt_d     = hdr_cnt_s;
               k_d       = 11'd0;
               bad_idx_d = hdr_bad_idx_s;
               over_d    = hdr_over_s;
               if (hdr_bad_idx_s || hdr_over_s) err_d = 1'b1;
               else                             err_d = err_d;
            end else begin
               k_d = k_q;
            end
         end
         LOAD: begin
            if (accept_s) begin
               k_d = k_q + 11'd1;
               if (!bad_idx_q && (k_q < NUM_WT_W)) begin
                  wen_d  = WEN_ONE << idx_q;
                  wadd_d = k_q[9:0];
                  win_d  = s_data;
               end else begin
                  wen_d = '0;
               end
               if (last_s) begin
                  done_d = 1'b1;
                  if (!bad_idx_q && !over_q) loaded_d = loaded_d | (WEN_ONE << idx_q);
                  else                       loaded_d = loaded_d;
               end else begin
                  done_d = 1'b0;
               end
            end else begin
               k_d = k_q;
            end
         end
         default: begin
            wen_d = '0;
         end
      endcase
   end

   // Registered outputs and block context.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= 6'd0;
         cnt_q      <= 11'd0;
         k_q        <= 11'd0;
         bad_idx_q  <= 1'b0;
         over_q     <= 1'b0;
         wen        <= '0;
         wadd       <= 10'd0;
         win        <= 16'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         nrn_loaded <= '0;
         err        <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         k_q        <= k_d;
         bad_idx_q  <= bad_idx_d;
         over_q     <= over_d;
         wen        <= wen_d;
         wadd       <= wadd_d;
         win        <= win_d;
         busy       <= busy_d;
         done       <= done_d;
         nrn_loaded <= loaded_d;
         err        <= err_d;
      end
   end
endmodule

// File: tb/tb_weight_loader.sv
// Randomized self-checking bench for weight_loader against a block-level
// reference model of the expected write/done event sequence.
module tb_weight_loader;
   localparam int NN = 4;
   localparam int NW = 8;

   typedef struct {
      logic [3:0]  wen;
      logic [9:0]  wadd;
      logic [15:0] win;
      logic        done;
      int          cyc;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_en = 1'b1;
   logic          s_valid = 1'b0;
   logic [15:0]   s_data = 16'd0;
   logic          s_ready;
   logic          clr = 1'b0;
   logic [NN-1:0] wen;
   logic [9:0]    wadd;
   logic [15:0]   win;
   logic          busy, done;
   logic [NN-1:0] nrn_loaded;
   logic          err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   ev_t obs_q[$];
   ev_t exp_q[$];
   logic [NN-1:0] exp_loaded = '0;
   logic          exp_err = 1'b0;

   weight_loader #(.numNeuron(NN), .numWeight(NW)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .clr(clr), .wen(wen), .wadd(wadd), .win(win), .busy(busy),
      .done(done), .nrn_loaded(nrn_loaded), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Observed write/done events, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && (wen != '0 || done)) obs_q.push_back('{wen, wadd, win, done, cyc});
   end

   function automatic bit ev_eq(input ev_t a, input ev_t b);
      return (a.wen === b.wen) && (a.done === b.done) &&
             (b.wen == 4'd0 || (a.wadd === b.wadd && a.win === b.win));
   endfunction

   function automatic string ev_str(input ev_t e);
      return $sformatf("wen=%b wadd=%0d win=%h done=%b", e.wen, e.wadd, e.win, e.done);
   endfunction

   // Expected events of one whole block, from the header rules.
   function automatic void model_block(input logic [15:0] hdr, input logic [15:0] ws[$]);
      int  idx;
      int  cnt;
      bit  bad;
      bit  over;
      ev_t e;
      idx  = int'(hdr[15:10]);
      cnt  = int'(hdr[9:0]) + 1;
      bad  = (idx >= NN);
      over = (cnt > NW);
      for (int k = 0; k < cnt; k++) begin
         if (!bad && k < NW) begin
            e = '{4'(1 << idx), 10'(k), ws[k], (k == cnt - 1), 0};
            exp_q.push_back(e);
         end else if (k == cnt - 1) begin
            e = '{4'd0, 10'd0, 16'd0, 1'b1, 0};
            exp_q.push_back(e);
         end
      end
      if (!bad && !over) exp_loaded[idx] = 1'b1;
      if (bad || over) exp_err = 1'b1;
   endfunction

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [15:0] w, input bit gaps);
      bit acc;
      int guard;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            s_valid = 1'b0;
            s_data  = 16'($urandom);
            @(posedge clk);
            #1;
         end
      end
      s_valid = 1'b1;
      s_data  = w;
      acc     = 1'b0;
      guard   = 0;
      while (!acc) begin
         load_en = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         guard++;
         if (!acc && guard > 60) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout word=%h s_ready=%b required=1", w, s_ready);
            acc = 1'b1;
         end
      end
      s_valid = 1'b0;
      load_en = 1'b1;
   endtask

   task automatic send_block(input logic [15:0] hdr, input logic [15:0] ws[$], input bit gaps);
      model_block(hdr, ws);
      send_word(hdr, gaps);
      foreach (ws[i]) send_word(ws[i], gaps);
   endtask

   task automatic test_reset();
      load_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({wen, wadd, win, busy, done, nrn_loaded, err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got wen=%b wadd=%0d win=%h busy=%b done=%b loaded=%b err=%b required all 0",
                  wen, wadd, win, busy, done, nrn_loaded, err);
      end
      checks++;
      if (s_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_s_ready got=%b required=0", s_ready);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         failures++;
         $display("FAIL release_s_ready got=%b required=1", s_ready);
      end
      load_en = 1'b0;
      #1;
      checks++;
      if (s_ready !== 1'b0) begin
         failures++;
         $display("FAIL load_en_low_s_ready got=%b required=0", s_ready);
      end
      load_en = 1'b1;
      idle(2);
   endtask

   task automatic test_basic();
      logic [15:0] ws[$];
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < 8; i++) ws.push_back(16'h1000 + 16'(i));
      send_block(16'h0C07, ws, 1'b0);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL basic_count got=%0d required=%0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (!ev_eq(obs_q[i], exp_q[i])) begin
            failures++;
            $display("FAIL basic_ev%0d got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
         end
      end
      for (int i = 1; i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i].cyc - obs_q[i-1].cyc != 1) begin
            failures++;
            $display("FAIL basic_throughput ev%0d gap got=%0d required=1", i, obs_q[i].cyc - obs_q[i-1].cyc);
         end
      end
      checks++;
      if (nrn_loaded !== exp_loaded) begin failures++; $display("FAIL basic_loaded got=%b required=%b", nrn_loaded, exp_loaded); end
      checks++;
      if (err !== exp_err) begin failures++; $display("FAIL basic_err got=%b required=%b", err, exp_err); end
   endtask

   task automatic test_backpressure();
      logic [15:0] ws[$];
      int n0;
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < 8; i++) ws.push_back(16'h1000 + 16'(i));
      model_block(16'h0C07, ws);
      send_word(16'h0C07, 1'b1);
      for (int i = 0; i < 4; i++) send_word(ws[i], 1'b1);
      s_valid = 1'b1;
      s_data  = ws[4];
      load_en = 1'b0;
      @(posedge clk);
      #1;
      n0 = obs_q.size();
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b required=1", busy); end
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (obs_q.size() != n0) begin failures++; $display("FAIL stall_writes got=%0d required=%0d", obs_q.size(), n0); end
      load_en = 1'b1;
      for (int i = 4; i < 8; i++) send_word(ws[i], 1'b1);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL bp_count got=%0d required=%0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (!ev_eq(obs_q[i], exp_q[i])) begin
            failures++;
            $display("FAIL bp_ev%0d got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
         end
      end
      checks++;
      if (nrn_loaded !== exp_loaded) begin failures++; $display("FAIL bp_loaded got=%b required=%b", nrn_loaded, exp_loaded); end
   endtask

   task automatic test_bad_index();
      logic [15:0] ws[$];
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < 4; i++) ws.push_back(16'($urandom));
      send_block(16'h1403, ws, 1'b1);
      ws.delete();
      for (int i = 0; i < 2; i++) ws.push_back(16'($urandom));
      send_block(16'h0001, ws, 1'b1);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL badidx_count got=%0d required=%0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (!ev_eq(obs_q[i], exp_q[i])) begin
            failures++;
            $display("FAIL badidx_ev%0d got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
         end
      end
      checks++;
      if (nrn_loaded !== exp_loaded) begin failures++; $display("FAIL badidx_loaded got=%b required=%b", nrn_loaded, exp_loaded); end
      checks++;
      if (err !== exp_err) begin failures++; $display("FAIL badidx_err got=%b required=%b", err, exp_err); end
   endtask

   task automatic test_overlong();
      logic [15:0] ws[$];
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < 10; i++) ws.push_back(16'($urandom));
      send_block(16'h0409, ws, 1'b0);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL over_count got=%0d required=%0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (!ev_eq(obs_q[i], exp_q[i])) begin
            failures++;
            $display("FAIL over_ev%0d got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
         end
      end
      checks++;
      if (nrn_loaded !== exp_loaded) begin failures++; $display("FAIL over_loaded got=%b required=%b", nrn_loaded, exp_loaded); end
      checks++;
      if (err !== exp_err) begin failures++; $display("FAIL over_err got=%b required=%b", err, exp_err); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ws[$];
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      exp_loaded = '0;
      exp_err    = 1'b0;
      obs_q.delete();
      exp_q.delete();
      ws.push_back(16'hAAAA);
      send_block(16'h0000, ws, 1'b0);
      ws.delete();
      ws.push_back(16'hBBBB);
      send_block(16'h0800, ws, 1'b0);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL b2b_count got=%0d required=%0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (!ev_eq(obs_q[i], exp_q[i])) begin
            failures++;
            $display("FAIL b2b_ev%0d got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
         end
      end
      if (obs_q.size() == 2) begin
         checks++;
         if (obs_q[1].cyc - obs_q[0].cyc != 2) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d required=2", obs_q[1].cyc - obs_q[0].cyc);
         end
      end
      checks++;
      if (nrn_loaded !== exp_loaded) begin failures++; $display("FAIL b2b_loaded got=%b required=%b", nrn_loaded, exp_loaded); end
      checks++;
      if (err !== exp_err) begin failures++; $display("FAIL b2b_err got=%b required=%b", err, exp_err); end
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      exp_loaded = '0;
      exp_err    = 1'b0;
      checks++;
      if ({nrn_loaded, err} !== {exp_loaded, exp_err}) begin
         failures++;
         $display("FAIL clr_result got loaded=%b err=%b required loaded=%b err=%b", nrn_loaded, err, exp_loaded, exp_err);
      end
   endtask

   task automatic test_clr_collision();
      logic [15:0] ws[$];
      obs_q.delete();
      exp_q.delete();
      ws.push_back(16'($urandom));
      send_block(16'h0800, ws, 1'b0);
      send_block(16'h1400, ws, 1'b0);
      idle(2);
      checks++;
      if ({nrn_loaded, err} !== {exp_loaded, exp_err}) begin
         failures++;
         $display("FAIL pre_clr got loaded=%b err=%b required loaded=%b err=%b", nrn_loaded, err, exp_loaded, exp_err);
      end
      exp_loaded = '0;
      exp_err    = 1'b0;
      clr = 1'b1;
      send_block(16'h0400, ws, 1'b0);
      clr = 1'b0;
      idle(2);
      checks++;
      if ({nrn_loaded, err} !== {exp_loaded, exp_err}) begin
         failures++;
         $display("FAIL clr_set_wins got loaded=%b err=%b required loaded=%b err=%b", nrn_loaded, err, exp_loaded, exp_err);
      end
   endtask

   task automatic test_random();
      logic [15:0] ws[$];
      int idx;
      int cnt;
      obs_q.delete();
      exp_q.delete();
      for (int b = 0; b < 12; b++) begin
         idx = $urandom_range(0, 5);
         cnt = $urandom_range(1, 10);
         ws.delete();
         for (int k = 0; k < cnt; k++) ws.push_back(16'($urandom));
         send_block({6'(idx), 10'(cnt - 1)}, ws, 1'b1);
      end
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL rand_count got=%0d required=%0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (!ev_eq(obs_q[i], exp_q[i])) begin
            failures++;
            $display("FAIL rand_ev%0d got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
         end
      end
      checks++;
      if (nrn_loaded !== exp_loaded) begin failures++; $display("FAIL rand_loaded got=%b required=%b", nrn_loaded, exp_loaded); end
      checks++;
      if (err !== exp_err) begin failures++; $display("FAIL rand_err got=%b required=%b", err, exp_err); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] ws[$];
      send_word(16'h0C07, 1'b0);
      for (int i = 0; i < 3; i++) send_word(16'h2000 + 16'(i), 1'b0);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b required=1", busy); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wen, wadd, win, busy, done, nrn_loaded, err} !== '0) begin
         failures++;
         $display("FAIL mid_reset_outputs got wen=%b wadd=%0d win=%h busy=%b done=%b loaded=%b err=%b required all 0",
                  wen, wadd, win, busy, done, nrn_loaded, err);
      end
      checks++;
      if (s_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_s_ready got=%b required=0", s_ready); end
      exp_loaded = '0;
      exp_err    = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      obs_q.delete();
      exp_q.delete();
      ws.push_back(16'h3333);
      ws.push_back(16'h4444);
      send_block(16'h0001, ws, 1'b0);
      idle(3);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL post_reset_count got=%0d required=%0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (!ev_eq(obs_q[i], exp_q[i])) begin
            failures++;
            $display("FAIL post_reset_ev%0d got %s required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
         end
      end
      checks++;
      if (nrn_loaded !== exp_loaded) begin failures++; $display("FAIL post_reset_loaded got=%b required=%b", nrn_loaded, exp_loaded); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_bad_index();
      test_overlong();
      test_back_to_back();
      test_clr_collision();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
